input_port_ctrl: RTL
====================

INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4: FIFO depth in flits; power of two, at least 2.
REQ-002 SHALL have parameter PAYLOAD_SZ, default 8: payload bits per flit.
REQ-003 SHALL define flit width FW = `ADDR_SZ + PAYLOAD_SZ; flit[FW-1 -: `ADDR_SZ] is the destination node id.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream link offers a flit.
REQ-007 in_data  input  FW  upstream flit.
REQ-008 in_ready  output  1  FIFO can accept a flit.
REQ-009 table_addr  output  `ADDR_SZ  head-flit destination, driven to the routing table.
REQ-010 table_data  input  `BITS_DIR  direction returned by the routing table, combinational on table_addr.
REQ-011 req_valid  output  1  request to the output arbiter.
REQ-012 req_dir  output  `BITS_DIR  requested output direction (`EAST/`WEST/`NORTH/`SOUTH/`LOCAL).
REQ-013 grant  input  1  arbiter grants the current request.
REQ-014 out_data  output  FW  head flit, valid whenever req_valid=1.
REQ-015 count  output  clog2(DEPTH)+1  flits currently stored.

Function
REQ-016 SHALL implement a DEPTH-entry circular FIFO with read/write pointers that wrap modulo DEPTH.
REQ-017 SHALL drive in_ready = (count != DEPTH), combinationally.
REQ-018 SHALL write in_data at the write pointer on an edge where in_valid=1 and in_ready=1.
REQ-019 SHALL ignore in_valid while in_ready=0: no write, no pointer or count change.
REQ-020 SHALL drive table_addr combinationally from the destination field of the head entry.
- When empty, table_addr SHALL be 0.
REQ-021 SHALL implement FSM states IDLE, ROUTE and REQ; the reset state is IDLE.
REQ-022 IDLE -> ROUTE when count != 0; otherwise stay in IDLE.
REQ-023 ROUTE: SHALL register table_data into dir_q, then go to REQ (route latency one cycle).
REQ-024 REQ: req_valid=1, req_dir=dir_q, out_data=head flit.
- These outputs SHALL be held stable until grant.
REQ-025 REQ with grant=1: pop the head at that edge.
- Next state is ROUTE if the post-pop count is nonzero, else IDLE.
REQ-026 req_valid SHALL be 0 in IDLE and ROUTE.
- grant SHALL be ignored outside REQ.
REQ-027 Simultaneous push and pop on one edge SHALL leave count unchanged and advance both pointers.
REQ-028 Pop from a full FIFO SHALL set in_ready=1 on the following cycle only; no same-cycle passthrough.
REQ-029 A push into an empty FIFO becomes visible to the FSM on the next cycle.
- Minimum write-to-req_valid latency is 2 cycles; first-flit cut-through is not allowed.
REQ-030 SHALL pass table_data through unmodified; the block performs no direction validity check.
REQ-031 count SHALL equal writes minus pops since reset, bounded 0..DEPTH.

Reset
REQ-032 On rst_n=0, asynchronously:
- count=0, pointers=0, FSM=IDLE, dir_q=0, req_valid=0, req_dir=0.
- in_ready=1, table_addr=0.
REQ-033 FIFO storage need not be cleared; out_data is don't-care while req_valid=0.
REQ-034 Reset asserted mid-operation (any state, any count) SHALL discard all stored flits and any pending request.
REQ-035 First write SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-036 Reset: rst_n=0 asynchronously with 3 flits stored in REQ
- -> immediately req_valid=0, count=0, in_ready=1.
REQ-037 Single flit dest=5, model table returns `EAST, grant tied 1:
- write at edge E0; req_valid=1 with req_dir=`EAST after E2; pop at E3; count 0, FSM IDLE after E3.
REQ-038 Fill: 5 consecutive in_valid flits with grant=0
- -> first 4 accepted, in_ready=0 after 4th, 5th dropped, count=4.
REQ-039 Back-pressure: grant=0 for 10 cycles in REQ
- -> req_valid, req_dir and out_data constant throughout; table changes ignored after ROUTE.
REQ-040 Simultaneous: count=2, push and granted pop on same edge
- -> count stays 2, next head routed via ROUTE, order preserved (FIFO).
REQ-041 Wrap: stream 10 flits dest 0..8,0 through DEPTH=4 with grant=1
- -> all 10 delivered in order, and pointers wrap without loss.

Source files
------------

// File: rtl/input_port_ctrl_if.sv
// input_port_ctrl_if: flit ingress, routing-table lookup and arbiter request bundle.
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif
`ifndef BITS_DIR
`define BITS_DIR 3
`endif
`ifndef LOCAL
`define LOCAL 3'd0
`define EAST 3'd1
`define WEST 3'd2
`define NORTH 3'd3
`define SOUTH 3'd4
`endif

interface input_port_ctrl_if #(
    parameter int DEPTH      = 4,
    parameter int PAYLOAD_SZ = 8
);
    localparam int FW = `ADDR_SZ + PAYLOAD_SZ;
    localparam int CW = $clog2(DEPTH) + 1;
    logic                 in_valid;
    logic [FW-1:0]        in_data;
    logic                 in_ready;
    logic [`ADDR_SZ-1:0]  table_addr;
    logic [`BITS_DIR-1:0] table_data;
    logic                 req_valid;
    logic [`BITS_DIR-1:0] req_dir;
    logic                 grant;
    logic [FW-1:0]        out_data;
    logic [CW-1:0]        count;
    modport slave (
        input  in_valid, in_data, table_data, grant,
        output in_ready, table_addr, req_valid, req_dir, out_data, count
    );
    modport master (
        output in_valid, in_data, table_data, grant,
        input  in_ready, table_addr, req_valid, req_dir, out_data, count
    );
endinterface

// File: rtl/input_port_ctrl.sv
// input_port_ctrl: router input port -- circular flit FIFO plus IDLE/ROUTE/REQ request FSM.
module input_port_ctrl #(
    parameter int DEPTH      = 4,
    parameter int PAYLOAD_SZ = 8
) (
    input logic              clk,
    input logic              rst_n,
    input_port_ctrl_if.slave bus
);
    localparam int FW = `ADDR_SZ + PAYLOAD_SZ;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ROUTE, REQ} state_t;

    logic [FW-1:0]        mem_q [DEPTH];
    logic [AW-1:0]        wr_q, rd_q;
    logic [CW-1:0]        count_q, count_d;
    logic [`BITS_DIR-1:0] dir_q, dir_d;
    state_t               state_q, state_d;
    logic                 push, pop;
    logic [FW-1:0]        head;

    assign head           = mem_q[rd_q];
    assign bus.in_ready   = count_q != CW'(DEPTH);
    assign push           = bus.in_valid && bus.in_ready;
    assign pop            = state_q == REQ && bus.grant;
    assign count_d        = count_q + CW'(push) - CW'(pop);
    assign bus.table_addr = count_q == '0 ? '0 : head[FW-1 -: `ADDR_SZ];
    assign bus.req_valid  = state_q == REQ;
    assign bus.req_dir    = dir_q;
    assign bus.out_data   = head;
    assign bus.count      = count_q;

    // Direction is latched once in ROUTE so later table changes cannot disturb a pending request.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE:    state_d = count_q != '0 ? ROUTE : IDLE;
            ROUTE: begin
                dir_d   = bus.table_data;
                state_d = REQ;
            end
            REQ:     state_d = !bus.grant ? REQ : (count_d != '0 ? ROUTE : IDLE);
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= '0;
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            count_q <= count_d;
            wr_q    <= push ? wr_q + AW'(1) : wr_q;
            rd_q    <= pop ? rd_q + AW'(1) : rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= bus.in_data;
    end
endmodule
